hit_guard: RTL and testbench

HIT_GUARD -- requirements
Module: hit_guard

---
 rtl/mega_pkg.sv | 21 ++
 rtl/frame_timer.sv | 39 +++
 rtl/hit_guard.sv | 134 +++++++++++++
 tb/tb_hit_guard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mega_pkg.sv
`default_nettype none
// ============================================================================
//  mega_pkg
//  Shared state encoding and default frame constants for the hit guard.
//  Revision: 1.0
// ============================================================================
package mega_pkg;

   localparam int c_hold_frames   = 8;
   localparam int c_invuln_frames = 60;
   localparam int c_blink_shift   = 2;

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_HOLD   = 2'd1,
      ST_INVULN = 2'd2,
      ST_DEAD   = 2'd3
   } guard_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
//  frame_timer
//  8-bit frame down-counter with load, zero flag and look-ahead count.
//  Revision: 1.0
// ============================================================================
module frame_timer (
   input  logic       frame_clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] value,
   output logic [7:0] next_count,
   output logic       zero
);

   logic [7:0] r_count;

   // Holds at zero instead of wrapping.
   always_comb begin
      next_count = r_count;
      if (load) begin
         next_count = value;
      end else if (r_count != 8'd0) begin
         next_count = r_count - 8'd1;
      end
   end

   always_ff @(posedge frame_clk) begin
      if (reset) begin
         r_count <= 8'd0;
      end else begin
         r_count <= next_count;
      end
   end

   assign zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/hit_guard.sv
`default_nettype none
// ============================================================================
//  hit_guard
//  Qualifies collisions into fixed-length hit pulses followed by invulnerability.
//  Revision: 1.0
// ============================================================================
module hit_guard
   import mega_pkg::*;
#(
   parameter int HOLD_FRAMES   = c_hold_frames,
   parameter int INVULN_FRAMES = c_invuln_frames,
   parameter int BLINK_SHIFT   = c_blink_shift
) (
   input  logic       frame_clk,
   input  logic       reset,
   input  logic       enemycol,
   input  logic       met1_col,
   input  logic [2:0] curr_health,
   output logic       hit,
   output logic       invuln,
   output logic       blink,
   output logic [7:0] hit_count
);

   localparam logic [7:0] c_hold_load   = 8'(HOLD_FRAMES - 1);
   localparam logic [7:0] c_invuln_load = 8'(INVULN_FRAMES - 1);

   guard_state_t r_state;
   guard_state_t w_state_next;

   logic       w_collision;
   logic       w_alive;
   logic       w_load;
   logic [7:0] w_load_value;
   logic [7:0] w_timer_next;
   logic       w_timer_zero;
   logic       w_count_inc;
   logic       w_count_clr;

   logic       r_hit;
   logic       r_invuln;
   logic       r_blink;
   logic [7:0] r_hit_count;

   assign w_collision = enemycol | met1_col;
   assign w_alive     = (curr_health != 3'd0);

   frame_timer u_frame_timer (
      .frame_clk  (frame_clk),
      .reset      (reset),
      .load       (w_load),
      .value      (w_load_value),
      .next_count (w_timer_next),
      .zero       (w_timer_zero)
   );

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_value = 8'd0;
      w_count_inc  = 1'b0;
      w_count_clr  = 1'b0;
      case (r_state)
         ST_ARMED: begin
            if (!w_alive) begin
               w_state_next = ST_DEAD;
            end else if (w_collision) begin
               w_state_next = ST_HOLD;
               w_load       = 1'b1;
               w_load_value = c_hold_load;
               w_count_inc  = 1'b1;
            end
         end
         // The hold window ignores health and collisions so the pulse is never cut short.
         ST_HOLD: begin
            if (w_timer_zero) begin
               w_state_next = ST_INVULN;
               w_load       = 1'b1;
               w_load_value = c_invuln_load;
            end
         end
         ST_INVULN: begin
            if (!w_alive) begin
               w_state_next = ST_DEAD;
            end else if (w_timer_zero) begin
               w_state_next = ST_ARMED;
            end
         end
         ST_DEAD: begin
            if (w_alive) begin
               w_state_next = ST_ARMED;
               w_count_clr  = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_ARMED;
         end
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (reset) begin
         r_state <= ST_ARMED;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge frame_clk) begin
      if (reset) begin
         r_hit       <= 1'b0;
         r_invuln    <= 1'b0;
         r_blink     <= 1'b0;
         r_hit_count <= 8'd0;
      end else begin
         r_hit    <= (w_state_next == ST_HOLD);
         r_invuln <= (w_state_next == ST_HOLD) || (w_state_next == ST_INVULN);
         r_blink  <= (w_state_next == ST_INVULN) && w_timer_next[BLINK_SHIFT];
         if (w_count_clr) begin
            r_hit_count <= 8'd0;
         end else if (w_count_inc && (r_hit_count != 8'hFF)) begin
            r_hit_count <= r_hit_count + 8'd1;
         end
      end
   end

   assign hit       = r_hit;
   assign invuln    = r_invuln;
   assign blink     = r_blink;
   assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_hit_guard.sv
`default_nettype none
// ============================================================================
//  tb_hit_guard
//  Self-checking bench: vector table, directed sequences and random traffic.
//  Revision: 1.0
// ============================================================================
module tb_hit_guard;

   localparam int HOLD   = 8;
   localparam int INV    = 60;
   localparam int BSHIFT = 2;

   logic       frame_clk = 1'b0;
   logic       reset = 1'b1;
   logic       enemycol = 1'b0;
   logic       met1_col = 1'b0;
   logic [2:0] curr_health = 3'd4;
   logic       hit;
   logic       invuln;
   logic       blink;
   logic [7:0] hit_count;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: frames left in each window, plus a dead flag.
   int hold_left = 0;
   int inv_left  = 0;
   bit dead      = 0;
   int count     = 0;

   hit_guard #(
      .HOLD_FRAMES   (HOLD),
      .INVULN_FRAMES (INV),
      .BLINK_SHIFT   (BSHIFT)
   ) dut (
      .frame_clk   (frame_clk),
      .reset       (reset),
      .enemycol    (enemycol),
      .met1_col    (met1_col),
      .curr_health (curr_health),
      .hit         (hit),
      .invuln      (invuln),
      .blink       (blink),
      .hit_count   (hit_count)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   task automatic model_step(input bit r, input bit col, input int h);
      if (r) begin
         hold_left = 0; inv_left = 0; dead = 0; count = 0;
      end else if (dead) begin
         if (h != 0) begin dead = 0; count = 0; end
      end else if (hold_left > 0) begin
         hold_left--;
         if (hold_left == 0) inv_left = INV;
      end else if (inv_left > 0) begin
         if (h == 0) begin inv_left = 0; dead = 1; end
         else inv_left--;
      end else begin
         if (h == 0) dead = 1;
         else if (col) begin
            hold_left = HOLD;
            count = (count < 255) ? count + 1 : 255;
         end
      end
   endtask

   function automatic int exp_blink();
      if (inv_left == 0 || hold_left > 0) return 0;
      return ((inv_left - 1) >> BSHIFT) & 1;
   endfunction

   task automatic cycle(input bit r, input bit e, input bit m, input int h);
      reset = r; enemycol = e; met1_col = m; curr_health = 3'(h);
      @(posedge frame_clk);
      model_step(r, e | m, h);
      #1;
      chk("hit", int'(hit), (hold_left > 0) ? 1 : 0);
      chk("invuln", int'(invuln), (hold_left > 0 || inv_left > 0) ? 1 : 0);
      chk("blink", int'(blink), exp_blink());
      chk("hit_count", int'(hit_count), count);
   endtask

   typedef struct {
      bit r, e, m;
      int h;
      int x_hit, x_inv, x_blink, x_cnt;
   } vec_t;

   vec_t vt[$];

   initial begin
      int hits, invs, run, toggles, nrise;
      int rise[$];
      bit pb, ph;

      // Table: reset, acceptance, ignored collisions in HOLD, mid-HOLD reset,
      // both inputs at once, death from ARMED, ignored collisions while dead, revival.
      vt.push_back('{1, 0, 0, 4, 0, 0, 0, 0});
      vt.push_back('{0, 1, 0, 4, 1, 1, 0, 1});
      vt.push_back('{0, 0, 1, 4, 1, 1, 0, 1});
      vt.push_back('{0, 1, 1, 4, 1, 1, 0, 1});
      vt.push_back('{0, 0, 0, 0, 1, 1, 0, 1});
      vt.push_back('{1, 1, 0, 4, 0, 0, 0, 0});
      vt.push_back('{0, 1, 1, 4, 1, 1, 0, 1});
      vt.push_back('{0, 0, 0, 0, 1, 1, 0, 1});
      vt.push_back('{1, 0, 0, 4, 0, 0, 0, 0});
      vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{0, 1, 1, 0, 0, 0, 0, 0});
      vt.push_back('{0, 1, 0, 4, 0, 0, 0, 0});
      vt.push_back('{0, 1, 0, 4, 1, 1, 0, 1});
      for (int i = 0; i < vt.size(); i++) begin
         cycle(vt[i].r, vt[i].e, vt[i].m, vt[i].h);
         chk("vec_hit", int'(hit), vt[i].x_hit);
         chk("vec_invuln", int'(invuln), vt[i].x_inv);
         chk("vec_blink", int'(blink), vt[i].x_blink);
         chk("vec_count", int'(hit_count), vt[i].x_cnt);
      end

      // Single hit: pulse length, invulnerability length, blink cadence.
      cycle(1, 0, 0, 4);
      cycle(0, 1, 0, 4);
      hits = int'(hit); invs = int'(invuln); run = 0; toggles = 0; pb = 0;
      for (int i = 0; i < 80; i++) begin
         cycle(0, 0, 0, 4);
         hits += int'(hit); invs += int'(invuln);
         if (invuln && !hit) begin
            if (blink != pb && run > 0) begin
               chk("blink_period", run, 4); toggles++; run = 1;
            end else run++;
            pb = blink;
         end
      end
      chk("single_hit_len", hits, HOLD);
      chk("single_invuln_len", invs, HOLD + INV);
      chk("blink_toggles", toggles, INV / 4 - 1);
      chk("single_count", int'(hit_count), 1);

      // Held collision: re-arms level-sensitively after each window.
      cycle(1, 0, 0, 4);
      ph = 0; rise.delete();
      for (int i = 1; i <= 200; i++) begin
         cycle(0, 0, 1, 4);
         if (hit && !ph) rise.push_back(i);
         ph = hit;
      end
      nrise = rise.size();
      chk("held_rises", nrise, 3);
      if (nrise == 3) begin
         chk("held_first", rise[0], 1);
         chk("held_gap1", rise[1] - rise[0], HOLD + INV + 1);
         chk("held_gap2", rise[2] - rise[1], HOLD + INV + 1);
      end
      chk("held_count", int'(hit_count), 3);

      // Death during invulnerability, then revival.
      cycle(1, 0, 0, 4);
      cycle(0, 1, 0, 4);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 4);
      cycle(0, 1, 0, 0);
      chk("death_invuln", int'(invuln), 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 0);
         chk("dead_ignores", int'(hit), 0);
      end
      cycle(0, 0, 0, 4);
      chk("revive_count", int'(hit_count), 0);

      // Mid-HOLD reset on the third hold cycle.
      cycle(1, 0, 0, 4);
      cycle(0, 1, 0, 4);
      cycle(0, 0, 0, 4);
      cycle(0, 0, 0, 4);
      cycle(1, 0, 0, 4);
      chk("midhold_rst_hit", int'(hit), 0);
      chk("midhold_rst_cnt", int'(hit_count), 0);

      // Saturation: 300 accepted hits.
      cycle(1, 0, 0, 4);
      for (int i = 0; i < 300 * (HOLD + INV + 1) + 5; i++) cycle(0, 1, 0, 4);
      chk("saturate", int'(hit_count), 255);

      // Randomized traffic against the model.
      cycle(1, 0, 0, 4);
      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 14) == 0),
               ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
